// File: rtl/pc_fetch_unit.sv
// Fetch unit: PC register, imem request FSM, IF/ID output reg with skid.
// Optional FETCH_ALIGN_CHECK_EN: misaligned redirect raises if_exc_adel.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
`ifdef FETCH_ALIGN_CHECK_EN
  output logic        if_exc_adel,
`endif
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc4
);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_WAIT, S_FULL, S_HOLD
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [31:0] r_pc;
  logic        r_squash, w_squash_nxt;
  logic        r_skid_valid;
  logic [31:0] r_skid_instr, r_skid_pc;
  logic        r_if_valid;
  logic [31:0] r_if_instr, r_if_pc, r_if_pc4;

  logic        w_free, w_consume, w_misalign;
  logic        w_load_mem, w_load_skid, w_fill_skid;
  logic [31:0] w_redir_pc;

`ifdef FETCH_ALIGN_CHECK_EN
  logic r_exc;
  assign w_misalign  = |redirect_pc[1:0];
  assign w_redir_pc  = redirect_pc;
  assign if_exc_adel = r_exc;
`else
  assign w_misalign  = 1'b0;
  assign w_redir_pc  = redirect_pc & 32'hFFFF_FFFC;
`endif

  assign imem_req  = (r_state == S_REQ);
  assign imem_addr = r_pc;
  assign if_valid  = r_if_valid;
  assign if_instr  = r_if_instr;
  assign if_pc     = r_if_pc;
  assign if_pc4    = r_if_pc4;

  always_comb begin
    w_free       = !r_if_valid || !stall;
    w_consume    = r_if_valid && !stall;
    w_state_nxt  = r_state;
    w_squash_nxt = r_squash;
    w_load_mem   = 1'b0;
    w_load_skid  = 1'b0;
    w_fill_skid  = 1'b0;
    if (redirect_valid) begin
      unique case (r_state)
        S_REQ: begin
          if (imem_gnt) begin
            w_state_nxt  = S_WAIT;
            w_squash_nxt = 1'b1;
          end
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            w_state_nxt  = S_REQ;
            w_squash_nxt = 1'b0;
          end else begin
            w_squash_nxt = 1'b1;
          end
        end
        S_HOLD: begin
          w_state_nxt = S_REQ;
          if (imem_rvalid) w_squash_nxt = 1'b0;
        end
        default: w_state_nxt = S_REQ;
      endcase
      if (w_misalign) w_state_nxt = S_HOLD;
    end else begin
      unique case (r_state)
        S_IDLE: w_state_nxt = S_REQ;
        S_REQ: begin
          if (imem_gnt) w_state_nxt = S_WAIT;
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            w_state_nxt = S_REQ;
            if (r_squash) begin
              w_squash_nxt = 1'b0;
            end else if (w_free) begin
              w_load_mem = 1'b1;
            end else begin
              w_fill_skid = 1'b1;
              w_state_nxt = S_FULL;
            end
          end
        end
        S_FULL: begin
          if (w_free) begin
            w_load_skid = 1'b1;
            w_state_nxt = S_REQ;
          end
        end
        // a response still owed from before the misaligned redirect lands here
        S_HOLD: begin
          if (imem_rvalid) w_squash_nxt = 1'b0;
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_pc         <= RESET_PC;
      r_squash     <= 1'b0;
      r_skid_valid <= 1'b0;
      r_skid_instr <= '0;
      r_skid_pc    <= '0;
      r_if_valid   <= 1'b0;
      r_if_instr   <= '0;
      r_if_pc      <= '0;
      r_if_pc4     <= '0;
`ifdef FETCH_ALIGN_CHECK_EN
      r_exc        <= 1'b0;
`endif
    end else begin
      r_state  <= w_state_nxt;
      r_squash <= w_squash_nxt;
      if (redirect_valid) begin
        r_pc         <= w_redir_pc;
        r_skid_valid <= 1'b0;
        r_if_valid   <= 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
        r_exc        <= 1'b0;
        if (w_misalign) begin
          r_if_valid <= 1'b1;
          r_if_instr <= '0;
          r_if_pc    <= redirect_pc;
          r_if_pc4   <= redirect_pc + 32'd4;
          r_exc      <= 1'b1;
        end
`endif
      end else begin
        if (w_load_mem || w_fill_skid) r_pc <= r_pc + 32'd4;
        if (w_load_mem) begin
          r_if_valid <= 1'b1;
          r_if_instr <= imem_rdata;
          r_if_pc    <= r_pc;
          r_if_pc4   <= r_pc + 32'd4;
`ifdef FETCH_ALIGN_CHECK_EN
          r_exc      <= 1'b0;
`endif
        end else if (w_load_skid) begin
          r_if_valid   <= 1'b1;
          r_if_instr   <= r_skid_instr;
          r_if_pc      <= r_skid_pc;
          r_if_pc4     <= r_skid_pc + 32'd4;
          r_skid_valid <= 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
          r_exc        <= 1'b0;
`endif
        end else if (w_consume) begin
          r_if_valid <= 1'b0;
        end
        if (w_fill_skid) begin
          r_skid_valid <= 1'b1;
          r_skid_instr <= imem_rdata;
          r_skid_pc    <= r_pc;
        end
      end
    end
  end

endmodule
